// File: rtl/tank_move_sched.sv
// -----------------------------------------------------------------------------
// tank_move_sched
//
// Frame-synchronous movement scheduler for the tank state registers that the
// VGA pixel renderer reads. Once per video frame (on i_frame_start) it walks
// the N_TANKS slots in fixed order, one slot per clock. For each slot it
// applies the latched direction command, clamps moves at the grid border and
// suppresses moves onto a cell occupied by another live tank.
//
// Ports:
//   i_clk_25m      pixel clock, all logic on its rising edge
//   i_rst_n        asynchronous active-low reset
//   i_frame_start  one-cycle pulse at start of vertical blanking
//   i_tank_exist   bit k = slot k is alive
//   i_cmd          one-hot command per slot at [4k+3:4k]
//                  (1000 up, 0100 down, 0010 left, 0001 right, 0000 none)
//   o_tank_x       cell x of slot k at [6k+5:6k]
//   o_tank_y       cell y of slot k at [6k+5:6k]
//   o_tank_dir     facing of slot k at [2k+1:2k] (0 up, 1 down, 2 left, 3 right)
//   o_busy         high from PREP through DONE (sweep in progress)
//   o_update_done  one-cycle pulse during DONE
//   o_overrun      sticky, set when i_frame_start arrives outside IDLE
//   o_dbg_state    current FSM state (IDLE=0, PREP=1, SVC=2, DONE=3)
//
// Handshake: i_frame_start is a single-cycle request accepted only in IDLE;
// a request seen in any other state is dropped and flagged on o_overrun.
// o_update_done is a single-cycle completion strobe with no back-pressure.
// -----------------------------------------------------------------------------
module tank_move_sched #(
  parameter int N_TANKS  = 5,
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MOVE_DIV = 4
) (
  input  logic                   i_clk_25m,
  input  logic                   i_rst_n,
  input  logic                   i_frame_start,
  input  logic [N_TANKS-1:0]     i_tank_exist,
  input  logic [4*N_TANKS-1:0]   i_cmd,
  output logic [6*N_TANKS-1:0]   o_tank_x,
  output logic [6*N_TANKS-1:0]   o_tank_y,
  output logic [2*N_TANKS-1:0]   o_tank_dir,
  output logic                   o_busy,
  output logic                   o_update_done,
  output logic                   o_overrun,
  output logic [1:0]             o_dbg_state
);

  localparam int IDX_W = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;
  localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TANKS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
  localparam logic [5:0]       X_MAX    = 6'(GRID_W - 1);
  localparam logic [5:0]       Y_MAX    = 6'(GRID_H - 1);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_SVC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Power-on placement: slot 0 near the bottom facing up, others along the top
  // facing down, spread 12 cells apart.
  function automatic logic [5:0] rst_x(input int k);
    return 6'(4 + 12 * k);
  endfunction

  function automatic logic [5:0] rst_y(input int k);
    return (k == 0) ? 6'(GRID_H - 4) : 6'd3;
  endfunction

  function automatic logic [1:0] rst_dir(input int k);
    return (k == 0) ? DIR_UP : DIR_DOWN;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [DIV_W-1:0] r_div;
  logic             r_step_en;
  logic             r_overrun;

  logic [5:0] r_x       [N_TANKS];
  logic [5:0] r_y       [N_TANKS];
  logic [1:0] r_dir     [N_TANKS];
  logic       r_pend_v  [N_TANKS];
  logic [1:0] r_pend_dir[N_TANKS];

  logic       w_cmd_vld [N_TANKS];
  logic [1:0] w_cmd_dir [N_TANKS];

  logic [5:0] w_cur_x;
  logic [5:0] w_cur_y;
  logic [5:0] w_tgt_x;
  logic [5:0] w_tgt_y;
  logic [1:0] w_pd;
  logic       w_pv;
  logic       w_alive;
  logic       w_at_edge;
  logic       w_blocked;
  logic       w_do_turn;
  logic       w_do_move;

  // ---------------------------------------------------------------------------
  // Command decode: only exact one-hot patterns are legal; anything with two
  // or more bits set, and 0000, produce no capture.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < N_TANKS; k++) begin
      w_cmd_vld[k] = 1'b0;
      w_cmd_dir[k] = DIR_UP;
      case (i_cmd[4*k +: 4])
        4'b1000: begin w_cmd_vld[k] = 1'b1; w_cmd_dir[k] = DIR_UP;    end
        4'b0100: begin w_cmd_vld[k] = 1'b1; w_cmd_dir[k] = DIR_DOWN;  end
        4'b0010: begin w_cmd_vld[k] = 1'b1; w_cmd_dir[k] = DIR_LEFT;  end
        4'b0001: begin w_cmd_vld[k] = 1'b1; w_cmd_dir[k] = DIR_RIGHT; end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_frame_start) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_SVC;
      S_SVC:   if (r_idx == LAST_IDX) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Slot service datapath for the slot selected by r_idx.
  // Because slots are written back one per cycle, the register array already
  // holds this-sweep values for j<k and pre-sweep values for j>k, which is
  // exactly the ordering the blocking rule needs.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_cur_x   = r_x[r_idx];
    w_cur_y   = r_y[r_idx];
    w_pv      = r_pend_v[r_idx];
    w_pd      = r_pend_dir[r_idx];
    w_alive   = i_tank_exist[r_idx];
    w_tgt_x   = w_cur_x;
    w_tgt_y   = w_cur_y;
    w_at_edge = 1'b0;
    w_blocked = 1'b0;

    // The +/-1 result may wrap here; w_at_edge keeps it from ever committing.
    case (w_pd)
      DIR_UP: begin
        w_at_edge = (w_cur_y == 6'd0);
        w_tgt_y   = w_cur_y - 6'd1;
      end
      DIR_DOWN: begin
        w_at_edge = (w_cur_y >= Y_MAX);
        w_tgt_y   = w_cur_y + 6'd1;
      end
      DIR_LEFT: begin
        w_at_edge = (w_cur_x == 6'd0);
        w_tgt_x   = w_cur_x - 6'd1;
      end
      default: begin
        w_at_edge = (w_cur_x >= X_MAX);
        w_tgt_x   = w_cur_x + 6'd1;
      end
    endcase

    for (int j = 0; j < N_TANKS; j++) begin
      if ((IDX_W'(j) != r_idx) && i_tank_exist[j] &&
          (r_x[j] == w_tgt_x) && (r_y[j] == w_tgt_y)) begin
        w_blocked = 1'b1;
      end
    end

    // Facing follows the command every sweep; position only on step frames.
    w_do_turn = (r_state == S_SVC) && w_alive && w_pv;
    w_do_move = w_do_turn && r_step_en && !w_at_edge && !w_blocked;
  end

  // ---------------------------------------------------------------------------
  // Control and tank state registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_div     <= '0;
      r_step_en <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < N_TANKS; k++) begin
        r_x[k]   <= rst_x(k);
        r_y[k]   <= rst_y(k);
        r_dir[k] <= rst_dir(k);
      end
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_PREP) begin
        r_idx <= '0;
      end else if ((r_state == S_SVC) && (r_idx != LAST_IDX)) begin
        r_idx <= r_idx + IDX_W'(1);
      end

      // The divider only advances on accepted frames; step_en marks the sweep
      // that closes each MOVE_DIV-frame period.
      if ((r_state == S_IDLE) && i_frame_start) begin
        r_step_en <= (r_div == DIV_LAST);
        r_div     <= (r_div == DIV_LAST) ? '0 : (r_div + DIV_W'(1));
      end

      if ((r_state != S_IDLE) && i_frame_start) begin
        r_overrun <= 1'b1;
      end

      if (w_do_turn) begin
        r_dir[r_idx] <= w_pd;
      end
      if (w_do_move) begin
        r_x[r_idx] <= w_tgt_x;
        r_y[r_idx] <= w_tgt_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pending command latches. A fresh legal command in the service cycle beats
  // the clear, so a command arriving mid-service is kept for the next sweep.
  // Dead slots are serviced too, which discards whatever they had latched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_25m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_TANKS; k++) begin
        r_pend_v[k]   <= 1'b0;
        r_pend_dir[k] <= DIR_UP;
      end
    end else begin
      for (int k = 0; k < N_TANKS; k++) begin
        if (w_cmd_vld[k]) begin
          r_pend_v[k]   <= 1'b1;
          r_pend_dir[k] <= w_cmd_dir[k];
        end else if ((r_state == S_SVC) && (r_idx == IDX_W'(k))) begin
          r_pend_v[k] <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from registers, so the renderer sees values that
  // only move at service edges.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_tank_x   = '0;
    o_tank_y   = '0;
    o_tank_dir = '0;
    for (int k = 0; k < N_TANKS; k++) begin
      o_tank_x[6*k +: 6]   = r_x[k];
      o_tank_y[6*k +: 6]   = r_y[k];
      o_tank_dir[2*k +: 2] = r_dir[k];
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_update_done = (r_state == S_DONE);
  assign o_overrun     = r_overrun;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_tank_move_sched.sv
module tb_tank_move_sched;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fs1 = 1'b0;
  logic         fs4 = 1'b0;
  logic [N-1:0] exist = '1;
  logic [4*N-1:0] cmd = '0;

  logic [6*N-1:0] x1, y1, x4, y4;
  logic [2*N-1:0] d1, d4;
  logic           busy1, upd1, ovr1, busy4, upd4, ovr4;
  logic [1:0]     st1, st4;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset block
  always #20 clk = ~clk;

  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not end, got timeout want finish");
    $fatal(1);
  end

  tank_move_sched #(.N_TANKS(N), .GRID_W(64), .GRID_H(48), .MOVE_DIV(1)) u_dut1 (
    .i_clk_25m(clk), .i_rst_n(rst_n), .i_frame_start(fs1),
    .i_tank_exist(exist), .i_cmd(cmd),
    .o_tank_x(x1), .o_tank_y(y1), .o_tank_dir(d1),
    .o_busy(busy1), .o_update_done(upd1), .o_overrun(ovr1), .o_dbg_state(st1)
  );

  tank_move_sched #(.N_TANKS(N), .GRID_W(64), .GRID_H(48), .MOVE_DIV(4)) u_dut4 (
    .i_clk_25m(clk), .i_rst_n(rst_n), .i_frame_start(fs4),
    .i_tank_exist(exist), .i_cmd(cmd),
    .o_tank_x(x4), .o_tank_y(y4), .o_tank_dir(d4),
    .o_busy(busy4), .o_update_done(upd4), .o_overrun(ovr4), .o_dbg_state(st4)
  );

  function automatic logic [5:0] f6(input logic [6*N-1:0] v, input int k);
    return v[6*k +: 6];
  endfunction

  function automatic logic [1:0] f2(input logic [2*N-1:0] v, input int k);
    return v[2*k +: 2];
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fs1 = 1'b0;
    fs4 = 1'b0;
    cmd = '0;
    exist = '1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_cmd(input int slot, input logic [3:0] val);
    cmd[4*slot +: 4] = val;
  endtask

  // One frame pulse; lat = cycles from frame_start cycle to update_done cycle.
  task automatic run_frame(input bit use4, output int lat, output bit busy_t1);
    @(negedge clk);
    if (use4) fs4 = 1'b1; else fs1 = 1'b1;
    @(negedge clk);
    fs1 = 1'b0;
    fs4 = 1'b0;
    lat = 1;
    busy_t1 = use4 ? busy4 : busy1;
    while (!(use4 ? upd4 : upd1) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic run_frames(input int n, input bit use4, inout int bad);
    int  lat;
    bit  b;
    for (int i = 0; i < n; i++) begin
      run_frame(use4, lat, b);
      if (lat != 7) bad++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [6*N-1:0] ex_x;
    logic [6*N-1:0] ex_y;
    logic [2*N-1:0] ex_d;
    ex_x = {6'd52, 6'd40, 6'd28, 6'd16, 6'd4};
    ex_y = {6'd3, 6'd3, 6'd3, 6'd3, 6'd44};
    ex_d = 10'b0101010100;
    do_reset();
    n_vec++; if (x1 !== ex_x) begin n_err++; $display("FAIL rst_x: got %h want %h", x1, ex_x); end
    n_vec++; if (y1 !== ex_y) begin n_err++; $display("FAIL rst_y: got %h want %h", y1, ex_y); end
    n_vec++; if (d1 !== ex_d) begin n_err++; $display("FAIL rst_dir: got %b want %b", d1, ex_d); end
    n_vec++; if ({busy1, upd1, ovr1} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {busy1, upd1, ovr1}); end
    n_vec++; if (x4 !== ex_x) begin n_err++; $display("FAIL rst_x_div4: got %h want %h", x4, ex_x); end
  endtask

  task automatic test_step_every_frame();
    int lat;
    bit b;
    do_reset();
    set_cmd(0, 4'b0001);
    for (int f = 1; f <= 3; f++) begin
      run_frame(1'b0, lat, b);
      n_vec++; if (lat != 7) begin n_err++; $display("FAIL latency f%0d: got %0d want 7", f, lat); end
      n_vec++; if (b !== 1'b1) begin n_err++; $display("FAIL busy_t1 f%0d: got %b want 1", f, b); end
      n_vec++; if (f6(x1, 0) !== 6'(4 + f)) begin n_err++; $display("FAIL step_x f%0d: got %0d want %0d", f, f6(x1, 0), 4 + f); end
    end
    n_vec++; if (f2(d1, 0) !== 2'd3) begin n_err++; $display("FAIL step_dir: got %0d want 3", f2(d1, 0)); end
    n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL step_busy_idle: got %b want 0", busy1); end
  endtask

  task automatic test_divider();
    int lat;
    bit b;
    logic [5:0] ex;
    do_reset();
    set_cmd(0, 4'b0010);
    for (int f = 1; f <= 8; f++) begin
      run_frame(1'b1, lat, b);
      ex = (f < 4) ? 6'd4 : ((f < 8) ? 6'd3 : 6'd2);
      n_vec++; if (f6(x4, 0) !== ex) begin n_err++; $display("FAIL div_x f%0d: got %0d want %0d", f, f6(x4, 0), ex); end
      if (f == 1) begin
        n_vec++; if (f2(d4, 0) !== 2'd2) begin n_err++; $display("FAIL div_dir f1: got %0d want 2", f2(d4, 0)); end
      end
    end
  endtask

  task automatic test_boundary();
    int bad = 0;
    do_reset();
    set_cmd(0, 4'b0010);
    set_cmd(1, 4'b0100);
    set_cmd(2, 4'b1000);
    set_cmd(4, 4'b0001);
    run_frames(46, 1'b0, bad);
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bnd_latency: got %0d bad frames want 0", bad); end
    n_vec++; if ({f6(x1, 0), f6(y1, 0), f2(d1, 0)} !== {6'd0, 6'd44, 2'd2}) begin
      n_err++; $display("FAIL bnd_left: got x%0d y%0d d%0d want x0 y44 d2", f6(x1, 0), f6(y1, 0), f2(d1, 0)); end
    n_vec++; if ({f6(x1, 1), f6(y1, 1), f2(d1, 1)} !== {6'd16, 6'd47, 2'd1}) begin
      n_err++; $display("FAIL bnd_down: got x%0d y%0d d%0d want x16 y47 d1", f6(x1, 1), f6(y1, 1), f2(d1, 1)); end
    n_vec++; if ({f6(x1, 2), f6(y1, 2), f2(d1, 2)} !== {6'd28, 6'd0, 2'd0}) begin
      n_err++; $display("FAIL bnd_up: got x%0d y%0d d%0d want x28 y0 d0", f6(x1, 2), f6(y1, 2), f2(d1, 2)); end
    n_vec++; if ({f6(x1, 4), f6(y1, 4), f2(d1, 4)} !== {6'd63, 6'd3, 2'd3}) begin
      n_err++; $display("FAIL bnd_right: got x%0d y%0d d%0d want x63 y3 d3", f6(x1, 4), f6(y1, 4), f2(d1, 4)); end
    n_vec++; if ({f6(x1, 3), f6(y1, 3), f2(d1, 3)} !== {6'd40, 6'd3, 2'd1}) begin
      n_err++; $display("FAIL bnd_idle_slot: got x%0d y%0d d%0d want x40 y3 d1", f6(x1, 3), f6(y1, 3), f2(d1, 3)); end
  endtask

  task automatic test_blocking();
    int bad = 0;
    do_reset();
    set_cmd(0, 4'b0001); set_cmd(1, 4'b0100);
    run_frames(6, 1'b0, bad);                     // s0 (10,44) s1 (16,9)
    set_cmd(0, 4'b1000); set_cmd(1, 4'b0010);
    run_frames(5, 1'b0, bad);                     // s0 (10,39) s1 (11,9)
    set_cmd(1, 4'b0100);
    run_frames(11, 1'b0, bad);                    // s0 (10,28) s1 (11,20)
    exist = 5'b11101; set_cmd(1, 4'b0000);
    run_frames(8, 1'b0, bad);                     // s0 (10,20), s1 held
    n_vec++; if ({f6(x1, 0), f6(y1, 0), f6(x1, 1), f6(y1, 1)} !== {6'd10, 6'd20, 6'd11, 6'd20}) begin
      n_err++; $display("FAIL blk_setup: got s0(%0d,%0d) s1(%0d,%0d) want s0(10,20) s1(11,20)",
                        f6(x1, 0), f6(y1, 0), f6(x1, 1), f6(y1, 1)); end
    exist = 5'b11110; set_cmd(0, 4'b0000);
    run_frames(1, 1'b0, bad);                     // drains slot0's stale command
    exist = 5'b11111; set_cmd(1, 4'b0010);
    run_frames(1, 1'b0, bad);
    n_vec++; if ({f6(x1, 1), f6(y1, 1), f2(d1, 1)} !== {6'd11, 6'd20, 2'd2}) begin
      n_err++; $display("FAIL blk_blocked: got x%0d y%0d d%0d want x11 y20 d2", f6(x1, 1), f6(y1, 1), f2(d1, 1)); end
    n_vec++; if ({f6(x1, 0), f6(y1, 0)} !== {6'd10, 6'd20}) begin
      n_err++; $display("FAIL blk_s0_still: got (%0d,%0d) want (10,20)", f6(x1, 0), f6(y1, 0)); end
    exist = 5'b11110;
    run_frames(1, 1'b0, bad);
    n_vec++; if ({f6(x1, 1), f6(y1, 1)} !== {6'd10, 6'd20}) begin
      n_err++; $display("FAIL blk_dead_pass: got (%0d,%0d) want (10,20)", f6(x1, 1), f6(y1, 1)); end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL blk_latency: got %0d bad frames want 0", bad); end
  endtask

  task automatic test_overrun_and_reset();
    int cyc;
    int seen;
    do_reset();
    set_cmd(0, 4'b0001);
    @(negedge clk); fs1 = 1'b1;                   // cycle T
    @(negedge clk); fs1 = 1'b0;                   // T+1
    @(negedge clk);                               // T+2
    @(negedge clk); fs1 = 1'b1;                   // T+3, while busy
    @(negedge clk); fs1 = 1'b0;                   // T+4
    n_vec++; if (ovr1 !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", ovr1); end
    cyc = 0;
    while (!upd1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_vec++; if (cyc >= 20) begin n_err++; $display("FAIL ovr_done_timeout: got %0d cycles want <20", cyc); end
    repeat (3) @(negedge clk);
    n_vec++; if ({f6(x1, 0), ovr1, busy1} !== {6'd5, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL ovr_single_sweep: got x%0d ovr%b busy%b want x5 ovr1 busy0", f6(x1, 0), ovr1, busy1); end

    // second sweep, reset in the middle of it
    @(negedge clk); fs1 = 1'b1;                   // T'
    @(negedge clk); fs1 = 1'b0;                   // T'+1
    repeat (3) @(negedge clk);                    // T'+4
    n_vec++; if ({f6(x1, 0), busy1} !== {6'd6, 1'b1}) begin
      n_err++; $display("FAIL mid_sweep: got x%0d busy%b want x6 busy1", f6(x1, 0), busy1); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({f6(x1, 0), f2(d1, 0), busy1, upd1, ovr1} !== {6'd4, 2'd0, 3'b000}) begin
      n_err++; $display("FAIL mid_reset: got x%0d d%0d busy%b upd%b ovr%b want x4 d0 000",
                        f6(x1, 0), f2(d1, 0), busy1, upd1, ovr1); end
    set_cmd(0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (upd1) seen++;
    end
    n_vec++; if ({seen[3:0], f6(x1, 0), busy1} !== {4'd0, 6'd4, 1'b0}) begin
      n_err++; $display("FAIL post_reset_quiet: got done%0d x%0d busy%b want done0 x4 busy0", seen, f6(x1, 0), busy1); end
  endtask

  task automatic test_cmd_filter();
    int lat;
    int cyc;
    bit b;
    do_reset();
    set_cmd(2, 4'b0110);
    run_frame(1'b0, lat, b);
    n_vec++; if ({f6(y1, 2), f2(d1, 2)} !== {6'd3, 2'd1}) begin
      n_err++; $display("FAIL illegal_cmd: got y%0d d%0d want y3 d1", f6(y1, 2), f2(d1, 2)); end
    set_cmd(2, 4'b0000);
    @(negedge clk); fs1 = 1'b1;                   // T
    @(negedge clk); fs1 = 1'b0;                   // T+1
    repeat (3) @(negedge clk);                    // T+4: slot2 service cycle
    set_cmd(2, 4'b1000);
    @(negedge clk);                               // T+5
    set_cmd(2, 4'b0000);
    cyc = 0;
    while (!upd1 && cyc < 20) begin @(negedge clk); cyc++; end
    @(negedge clk);
    n_vec++; if ({f6(y1, 2), f2(d1, 2)} !== {6'd3, 2'd1}) begin
      n_err++; $display("FAIL late_cmd_same_sweep: got y%0d d%0d want y3 d1", f6(y1, 2), f2(d1, 2)); end
    run_frame(1'b0, lat, b);
    n_vec++; if ({f6(y1, 2), f2(d1, 2)} !== {6'd2, 2'd0}) begin
      n_err++; $display("FAIL late_cmd_next_sweep: got y%0d d%0d want y2 d0", f6(y1, 2), f2(d1, 2)); end
  endtask

  initial begin
    test_reset();
    test_step_every_frame();
    test_divider();
    test_boundary();
    test_blocking();
    test_overrun_and_reset();
    test_cmd_filter();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tank_move_sched.md
Name: tank_move_sched

Overview:
- Frame-synchronous movement scheduler for the tank state registers read by the VGA pixel renderer.
- Once per video frame, services N_TANKS tank slots in fixed order, one slot per cycle.
- Applies the latched player/AI direction commands, grid-boundary clamping and tank-vs-tank blocking.
- Exports packed x/y/direction vectors to the renderer and signals completion.

Parameters:
- N_TANKS, 5, number of tank slots.
- GRID_W, 64, horizontal cell count (640/10); x range 0..GRID_W-1.
- GRID_H, 48, vertical cell count (480/10); y range 0..GRID_H-1.
- MOVE_DIV, 4, frames per movement step (speed divider), ≥1.

Ports:
- clk_25m  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- tank_exist  in  N_TANKS  slot enable; bit k=1 means tank k is alive.
- cmd  in  4*N_TANKS  one-hot command per slot, bits [4k+3:4k]: 1000 up, 0100 down, 0010 left, 0001 right, 0000 none.
- tank_x  out  6*N_TANKS  cell x of slot k at [6k+5:6k].
- tank_y  out  6*N_TANKS  cell y of slot k at [6k+5:6k].
- tank_dir  out  2*N_TANKS  facing of slot k at [2k+1:2k]: 0 up, 1 down, 2 left, 3 right.
- busy  out  1  high while the service sweep runs.
- update_done  out  1  one-cycle pulse when the sweep completes.
- overrun  out  1  sticky; set when frame_start arrives while busy.

Behaviour:
- Reset values:
  - Slot k: x=4+12k; y=GRID_H-4 for k=0, 3 otherwise.
  - Slot k: dir=0 (up) for k=0, 1 (down) otherwise.
  - busy=0, update_done=0, overrun=0, all pending commands cleared, frame divider=0.
- Command capture (every cycle): for each slot, a legal one-hot nonzero cmd overwrites pend[k] (last wins). Illegal patterns (≥2 bits set) are ignored; 0000 leaves pend unchanged.
- FSM states: IDLE, PREP, SVC, DONE.
- IDLE: on frame_start go to PREP.
  - Frame divider increments, wrapping at MOVE_DIV-1.
  - step_en=1 for this sweep iff the divider was MOVE_DIV-1 before increment (MOVE_DIV=1: every frame).
- PREP: 1 cycle; busy=1, slot index k=0.
- SVC: 1 cycle per slot, k=0..N_TANKS-1, then DONE.
  - tank_exist[k]=0: no state change; pend[k] cleared.
  - pend[k]==0: no change.
  - pend[k]!=0: dir[k] takes the commanded direction, even when step_en=0.
  - If step_en=1, compute the target cell: up y-1, down y+1, left x-1, right x+1.
  - Boundary: move suppressed (position held, dir still updated) when y=0 & up, y=GRID_H-1 & down, x=0 & left, or x=GRID_W-1 & right. No wrap-around, ever.
  - Blocking: move suppressed if target equals the current (x,y) of any other existing slot. Slots j<k use values already updated this sweep; slots j>k use their pre-sweep values.
  - pend[k] cleared at service. A new legal cmd for slot k in the same cycle wins over the clear.
- DONE: 1 cycle; update_done=1, busy=0 next cycle, return to IDLE.
- Latency: frame_start at cycle T; PREP at T+1; slot k written at edge T+2+k (slot 4 at T+6); update_done high during cycle T+7. Sweep length = N_TANKS+3 cycles from frame_start to IDLE.
- frame_start while not IDLE: ignored (divider not advanced), overrun set. overrun is cleared only by reset.
- Reset mid-sweep: all state returns immediately to reset values; partial updates are discarded.
- Outputs change only at SVC edges (and reset), so the renderer sees a stable snapshot outside the sweep.
- Arithmetic: 6-bit unsigned. The ±1 result is range-checked before commit; underflow and overflow are never stored.

Test Plan:
- Reset -> tank_x slot0=4, slot1=16, slot4=52; tank_y slot0=44, others=3; tank_dir=10'b0101010100; busy=0.
- MOVE_DIV=1; cmd slot0=0001 held; 3 frame_start pulses -> slot0 x 4→7, dir=3; update_done exactly 7 cycles after each frame_start.
- MOVE_DIV=4; cmd slot0=0010 held over 8 frames -> x decrements only on frames 4 and 8 (x=2); dir=2 after the first frame.
- Slot0 at x=0, cmd left; slot1 at y=GRID_H-1, cmd down -> positions unchanged, dirs updated to 2 and 1.
- Slot0 at (10,20); slot1 at (11,20) commanded left -> slot1 blocked. tank_exist[0]=0 -> slot1 moves to (10,20) next step frame.
- frame_start pulsed at T and T+3 -> second pulse ignored, overrun=1 and stays set. Assert rst_n low at T+4 during the next sweep -> all outputs return to reset values.
- cmd 0110 on slot2 -> ignored, no dir change. cmd 1000 arriving in slot2's SVC cycle -> applied on the following sweep.
